fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches from instruction memory over req/ack, resolves
// branches at fetch time for the program counter, and buffers words toward decode.
module fetch_unit #(
    parameter logic [2:0] BRANCH_OP  = 3'b111,
    parameter logic [2:0] BRANCHZ_OP = 3'b110
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pc,
    input  logic       zero_flag,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic [7:0] pc_control,
    output logic [7:0] jump_offset,
    output logic       pc_advance,
    output logic       dec_valid,
    input  logic       dec_ready,
    output logic [7:0] dec_instr,
    output logic [7:0] dec_pc
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FULL
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] count;
    logic [1:0] count_next;
    logic [7:0] slot_instr;
    logic [7:0] slot_pc;
    logic       accept;
    logic       pop;
    logic       taken;
    logic [2:0] op;

    // Acks seen outside REQ are ignored entirely: no push, no PC movement.
    assign accept     = mem_ack && (state == REQ);
    assign pop        = dec_valid && dec_ready;
    assign dec_valid  = (count != 2'd0);
    assign mem_addr   = pc;
    assign pc_advance = accept;

    assign op          = mem_rdata[7:5];
    assign taken       = accept && ((op == BRANCH_OP) || ((op == BRANCHZ_OP) && zero_flag));
    assign pc_control  = taken ? 8'hFF : 8'h00;
    assign jump_offset = taken ? {{3{mem_rdata[4]}}, mem_rdata[4:0]} : 8'h00;

    assign count_next = count + {1'b0, accept} - {1'b0, pop};

    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (accept && (count_next == 2'd2)) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (count_next < 2'd2) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // mem_req is registered from the next state so it rises together with REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mem_req <= 1'b0;
        end else begin
            state   <= state_next;
            mem_req <= (state_next == REQ);
        end
    end

    // Head entry lives in dec_instr/dec_pc; the second entry waits in slot_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= 2'd0;
            dec_instr  <= 8'h00;
            dec_pc     <= 8'h00;
            slot_instr <= 8'h00;
            slot_pc    <= 8'h00;
        end else begin
            count <= count_next;
            if (pop && (count == 2'd2)) begin
                dec_instr <= slot_instr;
                dec_pc    <= slot_pc;
            end
            if (accept) begin
                if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
                    dec_instr <= mem_rdata;
                    dec_pc    <= pc;
                end else begin
                    slot_instr <= mem_rdata;
                    slot_pc    <= pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a queue-based reference model; the bench also plays the program counter.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pc = 8'h00;
    logic       zero_flag = 1'b0;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] pc_control;
    logic [7:0] jump_offset;
    logic       pc_advance;
    logic       dec_valid;
    logic       dec_ready = 1'b0;
    logic [7:0] dec_instr;
    logic [7:0] dec_pc;

    logic       pc_set = 1'b0;
    logic [7:0] pc_set_val = 8'h00;
    int         total = 0;
    int         bad = 0;

    typedef struct packed {
        logic [7:0] instr;
        logic [7:0] addr;
    } entry_t;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .zero_flag   (zero_flag),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .pc_control  (pc_control),
        .jump_offset (jump_offset),
        .pc_advance  (pc_advance),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc)
    );

    always #5 clk = ~clk;

    // Program counter as seen by the fetch unit; pc_set lets tests preload it.
    always @(posedge clk) begin
        if (pc_set) pc <= pc_set_val;
        else if (pc_advance) pc <= pc + 8'd1 + (pc_control & jump_offset);
    end

    task automatic apply_stimulus(input logic ack, input logic [7:0] rdata, input logic zf, input logic rdy);
        @(negedge clk);
        mem_ack   = ack;
        mem_rdata = rdata;
        zero_flag = zf;
        dec_ready = rdy;
        #1;
    endtask

    // Returns just after reset release; the next applied cycle is the first REQ cycle.
    task automatic do_reset(input logic [7:0] start_pc);
        @(negedge clk);
        rst_n = 1'b0;
        mem_ack = 1'b0;
        dec_ready = 1'b0;
        zero_flag = 1'b0;
        pc_set_val = start_pc;
        pc_set = 1'b1;
        @(negedge clk);
        pc_set = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 8'hE1;
        zero_flag = 1'b1;
        pc_set_val = 8'h00;
        pc_set = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req: got %b want 0", mem_req); end
        total++; if (dec_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", dec_valid); end
        total++; if (dec_instr !== 8'h00 || dec_pc !== 8'h00) begin bad++; $display("[TB] FAIL reset_head: got %h/%h want 00/00", dec_instr, dec_pc); end
        total++; if (pc_control !== 8'h00 || jump_offset !== 8'h00 || pc_advance !== 1'b0) begin bad++; $display("[TB] FAIL reset_pcif: got %h/%h/%b want 00/00/0", pc_control, jump_offset, pc_advance); end
        mem_ack = 1'b0;
        @(negedge clk);
        pc_set = 1'b0;
        rst_n = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL idle_req: got %b want 0", mem_req); end
        @(negedge clk);
        #1;
        total++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin bad++; $display("[TB] FAIL first_req: got %b/%h want 1/00", mem_req, mem_addr); end
    endtask

    task automatic test_linear;
        do_reset(8'h00);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 8'(i + 1), 1'b0, 1'b1);
            total++; if (mem_addr !== 8'(i) || pc_control !== 8'h00 || pc_advance !== 1'b1) begin bad++; $display("[TB] FAIL linear_fetch%0d: got addr %h ctl %h adv %b want %h/00/1", i, mem_addr, pc_control, pc_advance, 8'(i)); end
            if (i > 0) begin
                total++; if (dec_valid !== 1'b1 || dec_instr !== 8'(i) || dec_pc !== 8'(i - 1)) begin bad++; $display("[TB] FAIL linear_head%0d: got %b %h/%h want 1 %h/%h", i, dec_valid, dec_instr, dec_pc, 8'(i), 8'(i - 1)); end
            end
        end
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        total++; if (dec_valid !== 1'b1 || dec_instr !== 8'h03 || dec_pc !== 8'h02) begin bad++; $display("[TB] FAIL linear_last: got %b %h/%h want 1 03/02", dec_valid, dec_instr, dec_pc); end
    endtask

    task automatic test_branch;
        do_reset(8'h05);
        apply_stimulus(1'b1, 8'hE3, 1'b0, 1'b1);
        total++; if (pc_control !== 8'hFF || jump_offset !== 8'h03) begin bad++; $display("[TB] FAIL br_outputs: got %h/%h want FF/03", pc_control, jump_offset); end
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        total++; if (mem_addr !== 8'h09) begin bad++; $display("[TB] FAIL br_target: got %h want 09", mem_addr); end
        do_reset(8'hFE);
        apply_stimulus(1'b1, 8'hE3, 1'b0, 1'b1);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        total++; if (mem_addr !== 8'h02) begin bad++; $display("[TB] FAIL br_wrap_fwd: got %h want 02", mem_addr); end
        do_reset(8'h01);
        apply_stimulus(1'b1, 8'hFE, 1'b0, 1'b1);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        total++; if (mem_addr !== 8'h00) begin bad++; $display("[TB] FAIL br_wrap_back: got %h want 00", mem_addr); end
    endtask

    task automatic test_cond_branch;
        do_reset(8'h10);
        apply_stimulus(1'b1, 8'hDE, 1'b1, 1'b1);
        total++; if (pc_control !== 8'hFF || jump_offset !== 8'hFE) begin bad++; $display("[TB] FAIL brz_taken: got %h/%h want FF/FE", pc_control, jump_offset); end
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        total++; if (mem_addr !== 8'h0F) begin bad++; $display("[TB] FAIL brz_taken_target: got %h want 0F", mem_addr); end
        do_reset(8'h10);
        apply_stimulus(1'b1, 8'hDE, 1'b0, 1'b1);
        total++; if (pc_control !== 8'h00 || jump_offset !== 8'h00) begin bad++; $display("[TB] FAIL brz_not_taken: got %h/%h want 00/00", pc_control, jump_offset); end
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        total++; if (mem_addr !== 8'h11) begin bad++; $display("[TB] FAIL brz_fallthrough: got %h want 11", mem_addr); end
    endtask

    task automatic test_backpressure;
        do_reset(8'h00);
        apply_stimulus(1'b1, 8'h21, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h22, 1'b0, 1'b0);
        total++; if (mem_addr !== 8'h01 || pc_advance !== 1'b1) begin bad++; $display("[TB] FAIL bp_second: got %h/%b want 01/1", mem_addr, pc_advance); end
        apply_stimulus(1'b1, 8'h23, 1'b0, 1'b0);
        total++; if (mem_req !== 1'b0 || pc_advance !== 1'b0) begin bad++; $display("[TB] FAIL bp_full: got req %b adv %b want 0/0", mem_req, pc_advance); end
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        total++; if (mem_req !== 1'b0 || dec_instr !== 8'h21) begin bad++; $display("[TB] FAIL bp_pop: got req %b head %h want 0/21", mem_req, dec_instr); end
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        total++; if (mem_req !== 1'b1 || mem_addr !== 8'h02) begin bad++; $display("[TB] FAIL bp_resume: got %b/%h want 1/02", mem_req, mem_addr); end
        total++; if (dec_valid !== 1'b1 || dec_instr !== 8'h22 || dec_pc !== 8'h01) begin bad++; $display("[TB] FAIL bp_head: got %b %h/%h want 1 22/01", dec_valid, dec_instr, dec_pc); end
    endtask

    task automatic test_wait_wrap;
        do_reset(8'hFF);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
            total++; if (mem_req !== 1'b1 || mem_addr !== 8'hFF) begin bad++; $display("[TB] FAIL wait_hold%0d: got %b/%h want 1/FF", i, mem_req, mem_addr); end
        end
        apply_stimulus(1'b1, 8'h44, 1'b0, 1'b1);
        total++; if (pc_advance !== 1'b1) begin bad++; $display("[TB] FAIL wait_ack: got %b want 1", pc_advance); end
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        total++; if (mem_addr !== 8'h00 || dec_instr !== 8'h44 || dec_pc !== 8'hFF) begin bad++; $display("[TB] FAIL wait_wrap: got %h %h/%h want 00 44/FF", mem_addr, dec_instr, dec_pc); end
    endtask

    task automatic test_reset_mid;
        do_reset(8'h30);
        apply_stimulus(1'b1, 8'h55, 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        total++; if (mem_req !== 1'b1 || dec_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre: got %b/%b want 1/1", mem_req, dec_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0 || dec_valid !== 1'b0 || dec_instr !== 8'h00) begin bad++; $display("[TB] FAIL mid_async: got %b/%b/%h want 0/0/00", mem_req, dec_valid, dec_instr); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++; if (mem_req !== 1'b1 || mem_addr !== 8'h31 || dec_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_restart: got %b/%h/%b want 1/31/0", mem_req, mem_addr, dec_valid); end
    endtask

    task automatic test_random;
        entry_t     q[$];
        entry_t     e;
        logic [7:0] exp_pc;
        logic [7:0] rd;
        logic       ack, rdy, zf, exp_req, acc, tk;
        int         wait_left;
        int         imm;
        exp_pc = 8'($urandom);
        do_reset(exp_pc);
        wait_left = -1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            exp_req = (q.size() < 2);
            rdy = ($urandom_range(0, 2) != 0);
            zf = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: rd = {3'b111, 5'($urandom)};
                1: rd = {3'b110, 5'($urandom)};
                default: rd = 8'($urandom);
            endcase
            ack = 1'b0;
            if (exp_req) begin
                if (wait_left < 0) wait_left = $urandom_range(0, 2);
                if (wait_left == 0) ack = 1'b1;
                else wait_left--;
            end else begin
                ack = ($urandom_range(0, 3) == 0);
            end
            apply_stimulus(ack, rd, zf, rdy);
            acc = ack && exp_req;
            tk = acc && ((rd[7:5] == 3'b111) || ((rd[7:5] == 3'b110) && zf));
            imm = rd[4] ? int'(rd[4:0]) - 32 : int'(rd[4:0]);
            total++; if (mem_req !== exp_req || mem_addr !== exp_pc || pc_advance !== acc) begin bad++; $display("[TB] FAIL rnd_fetch c%0d: got req %b addr %h adv %b want %b %h %b", cyc, mem_req, mem_addr, pc_advance, exp_req, exp_pc, acc); end
            if (acc) begin
                total++; if (pc_control !== (tk ? 8'hFF : 8'h00) || jump_offset !== (tk ? 8'(imm) : 8'h00)) begin bad++; $display("[TB] FAIL rnd_branch c%0d: got %h/%h instr %h zf %b", cyc, pc_control, jump_offset, rd, zf); end
            end
            total++; if (dec_valid !== (q.size() != 0)) begin bad++; $display("[TB] FAIL rnd_valid c%0d: got %b want %b", cyc, dec_valid, q.size() != 0); end
            if (q.size() != 0) begin
                total++; if (dec_instr !== q[0].instr || dec_pc !== q[0].addr) begin bad++; $display("[TB] FAIL rnd_head c%0d: got %h/%h want %h/%h", cyc, dec_instr, dec_pc, q[0].instr, q[0].addr); end
            end
            if (rdy && q.size() != 0) void'(q.pop_front());
            if (acc) begin
                e.instr = rd;
                e.addr = exp_pc;
                q.push_back(e);
                exp_pc = 8'((int'(exp_pc) + 1 + (tk ? imm : 0) + 256) % 256);
                wait_left = -1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_linear();
        test_branch();
        test_cond_branch();
        test_backpressure();
        test_wait_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
